// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   port_t  : requester identifiers used for round-robin bookkeeping
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side request ports and the shared memory bus.
//   Fetch port : if_req, if_addr -> if_rdata, if_valid
//   Data port  : d_req, d_we, d_be, d_addr, d_wdata -> d_rdata, d_valid
//   Memory bus : mem_req, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata, mem_ready
//   Status     : core_stall, bus_err
// Modports:
//   master : the arbiter (drives the memory bus and the completions)
//   slave  : the environment (core requesters plus memory responder)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;

  logic                  core_stall;
  logic                  bus_err;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid,
    output d_rdata, d_valid,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output core_stall, bus_err
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  core_stall, bus_err
  );

endinterface

// File: rtl/arb_timeout_cnt.sv
// Busy-phase watchdog for the memory port arbiter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count (asserted on grant)
//   enable     : count this cycle (BUSY and mem_ready low)
//   expired    : this counting cycle brings the count to TIMEOUT;
//                the arbiter aborts at the coming edge
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Decoding TIMEOUT-1 ahead of the increment lets the abort land on the
  // same edge at which the count reaches TIMEOUT.
  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one shared
// single-port memory bus, with round-robin arbitration on ties.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_port_arbiter_if master view
//                fetch/data requests in, one-cycle completion pulses out,
//                registered memory bus out, mem_rdata/mem_ready in,
//                core_stall (combinational from req) and bus_err pulse out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus
);

  state_t               state_q;
  port_t                last_grant_q;

  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [DATA_W/8-1:0]  mem_be_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;

  logic                 if_valid_q;
  logic                 d_valid_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic [DATA_W-1:0]    d_rdata_q;
  logic                 bus_err_q;

  logic                 if_req_m;
  logic                 d_req_m;
  logic                 grant_i;
  logic                 grant_d;
  logic                 busy;
  logic                 expired;
  logic [DATA_W-1:0]    rdata_cpl;

  // A port completing this cycle still holds its req; mask it so the
  // stale request is not granted again while the other port may be.
  assign if_req_m = bus.if_req & ~if_valid_q;
  assign d_req_m  = bus.d_req  & ~d_valid_q;

  assign busy    = (state_q != IDLE);
  assign grant_d = (state_q == IDLE) & d_req_m & (~if_req_m | (last_grant_q == PORT_I));
  assign grant_i = (state_q == IDLE) & if_req_m & ~grant_d;

  // Stores and aborts return zero; only a ready load/fetch returns bus data.
  assign rdata_cpl = (bus.mem_ready & ~mem_we_q) ? bus.mem_rdata : '0;

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_i | grant_d),
    .enable  (busy & ~bus.mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q      <= BUSY_D;
            last_grant_q <= PORT_D;
            mem_req_q    <= 1'b1;
            mem_we_q     <= bus.d_we;
            mem_be_q     <= bus.d_be;
            mem_addr_q   <= bus.d_addr;
            mem_wdata_q  <= bus.d_wdata;
          end else if (grant_i) begin
            state_q      <= BUSY_I;
            last_grant_q <= PORT_I;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '1;
            mem_addr_q   <= bus.if_addr;
            mem_wdata_q  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ready || expired) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            bus_err_q <= ~bus.mem_ready;
            if (state_q == BUSY_I) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= rdata_cpl;
            end else begin
              d_valid_q <= 1'b1;
              d_rdata_q <= rdata_cpl;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.core_stall = (bus.if_req & ~if_valid_q) | (bus.d_req & ~d_valid_q);

endmodule
